// File: rtl/frame_fetch_pipe.sv
// Pixel fetch engine: pulls sequential pixel word pairs from frame memory with one
// outstanding read, unpacks them into a small FIFO and serves R/G/B on display request.
//
// state   | meaning
// S_IDLE  | no frame active (after reset or after the last pixel of a frame was fetched)
// S_REQ   | request the next address whenever the FIFO has room
// S_WAIT  | request accepted, waiting for the returned word pair
// S_FLUSH | frame restarted during S_WAIT; drop the in-flight data, then restart at 0
module frame_fetch_pipe #(
    parameter int COLOR_W    = 10,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_PIX    = 307200,
    parameter int ADDR_W     = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic              i_mem_valid,
    input  logic [WORD_W-1:0] i_data_1,
    input  logic [WORD_W-1:0] i_data_2,
    input  logic              i_request,
    output logic [COLOR_W-1:0] o_vga_r,
    output logic [COLOR_W-1:0] o_vga_g,
    output logic [COLOR_W-1:0] o_vga_b,
    output logic              o_pix_valid,
    output logic              o_underflow,
    output logic              o_fetch_done
);

    localparam int H     = COLOR_W / 2;
    localparam int PIX_W = 3 * COLOR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fetch_done_q, fetch_done_d;
    logic              restart;
    logic              push;
    logic              pop;

    logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              fifo_empty;
    logic              fifo_full;

    logic [PIX_W-1:0]  pix_in;
    logic [PIX_W-1:0]  pix_q;
    logic              pix_valid_q;
    logic              underflow_q;

    // entry layout {r, g, b}; green is split across the two returned words
    assign pix_in = {i_data_2[COLOR_W-1:0],
                     i_data_1[COLOR_W+H-1:COLOR_W],
                     i_data_2[COLOR_W+H-1:COLOR_W],
                     i_data_1[COLOR_W-1:0]};

    generate
        if (WORD_W > COLOR_W + H) begin : g_spare_bits
            logic unused_hi;
            assign unused_hi = ^{i_data_1[WORD_W-1:COLOR_W+H], i_data_2[WORD_W-1:COLOR_W+H]};
        end
    endgenerate

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = i_request && !fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fetch_done_d = fetch_done_q;
        restart      = 1'b0;
        push         = 1'b0;
        o_mem_req    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_frame_start) begin
                    restart = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // a restart withdraws the request for this cycle
                if (i_frame_start) begin
                    restart = 1'b1;
                end else if (!fifo_full) begin
                    o_mem_req = 1'b1;
                    if (i_mem_ack) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_mem_valid) begin
                    if (i_frame_start) begin
                        restart = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        push = 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            fetch_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = S_REQ;
                        end
                    end
                end else if (i_frame_start) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (i_mem_valid) begin
                    restart = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (restart) begin
            addr_d       = '0;
            fetch_done_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pix_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (restart) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // a request against an empty FIFO still answers, with black, and flags underflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pix_valid_q <= i_request;
            if (i_request) begin
                pix_q <= fifo_empty ? '0 : fifo_mem[rd_ptr_q];
            end
            if (restart) begin
                underflow_q <= 1'b0;
            end else if (i_request && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign o_mem_addr   = addr_q;
    assign o_vga_r      = pix_q[3*COLOR_W-1:2*COLOR_W];
    assign o_vga_g      = pix_q[2*COLOR_W-1:COLOR_W];
    assign o_vga_b      = pix_q[COLOR_W-1:0];
    assign o_pix_valid  = pix_valid_q;
    assign o_underflow  = underflow_q;
    assign o_fetch_done = fetch_done_q;

endmodule

// File: tb/tb_frame_fetch_pipe.sv
// Bench for frame_fetch_pipe: a small memory responder plus a queue-based model of the
// pixel stream, with table-driven unpack vectors and directed restart/backpressure cases.
module tb_frame_fetch_pipe;

    localparam int CW    = 10;
    localparam int WW    = 16;
    localparam int DEPTH = 4;
    localparam int NPIX  = 8;
    localparam int AW    = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [WW-1:0] d1, d2;
    logic          request;
    logic [CW-1:0] vga_r, vga_g, vga_b;
    logic          pix_valid;
    logic          underflow;
    logic          fetch_done;

    always #5 clk = ~clk;

    frame_fetch_pipe #(
        .COLOR_W   (CW),
        .WORD_W    (WW),
        .FIFO_DEPTH(DEPTH),
        .NUM_PIX   (NPIX),
        .ADDR_W    (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_start(frame_start),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_valid  (mem_valid),
        .i_data_1     (d1),
        .i_data_2     (d2),
        .i_request    (request),
        .o_vga_r      (vga_r),
        .o_vga_g      (vga_g),
        .o_vga_b      (vga_b),
        .o_pix_valid  (pix_valid),
        .o_underflow  (underflow),
        .o_fetch_done (fetch_done)
    );

    typedef struct {
        logic [WW-1:0] w1;
        logic [WW-1:0] w2;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [3*CW-1:0] q[$];
    logic [3*CW-1:0] rgb_e;
    int  nxt_addr;
    bit  started, outstanding, flush_m, uf_m, done_m, pv_e;
    int  lat_cnt, lat_addr;
    int  ack_pct = 100;
    int  lat_lo = 1, lat_hi = 1;
    int  n_hs, last_hs_addr;
    logic [WW-1:0] mem1[NPIX];
    logic [WW-1:0] mem2[NPIX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3*CW-1:0] unpack(input logic [WW-1:0] a, input logic [WW-1:0] c);
        int lo, hm, r, g, b;
        logic [CW-1:0] rr, gg, bb;
        lo = 2 ** CW;
        hm = 2 ** (CW / 2);
        b  = int'(a) % lo;
        r  = int'(c) % lo;
        g  = ((int'(a) / lo) % hm) * hm + (int'(c) / lo) % hm;
        rr = r[CW-1:0];
        gg = g[CW-1:0];
        bb = b[CW-1:0];
        return {rr, gg, bb};
    endfunction

    task automatic reset_model();
        q.delete();
        nxt_addr    = 0;
        started     = 0;
        outstanding = 0;
        flush_m     = 0;
        uf_m        = 0;
        done_m      = 0;
        pv_e        = 0;
        rgb_e       = '0;
        lat_cnt     = 0;
    endtask

    task automatic restart_m();
        q.delete();
        nxt_addr = 0;
        uf_m     = 0;
        done_m   = 0;
        flush_m  = 0;
        started  = 1;
    endtask

    task automatic clear_inputs();
        frame_start = 0;
        request     = 0;
        mem_ack     = 0;
        mem_valid   = 0;
    endtask

    // Called at a negedge: compare the previous edge's results, then drive this cycle.
    task automatic step(input bit req_in, input bit fs_in);
        bit v, exp_req;
        int a;
        check("pix_valid", 64'(pix_valid), 64'(pv_e));
        check("rgb", 64'({vga_r, vga_g, vga_b}), 64'(rgb_e));
        check("underflow", 64'(underflow), 64'(uf_m));
        check("fetch_done", 64'(fetch_done), 64'(done_m));
        exp_req = started && !outstanding && !done_m && (q.size() < DEPTH);
        check("mem_req", 64'(mem_req), 64'(exp_req));

        v  = 0;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        if (outstanding && lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) v = 1;
        end
        if (v) begin
            a         = lat_addr % NPIX;
            d1        = mem1[a];
            d2        = mem2[a];
            mem_valid = 1;
        end
        if (mem_req && !outstanding && !fs_in && ($urandom_range(99) < 32'(ack_pct))) begin
            mem_ack = 1;
            check("mem_addr", 64'(mem_addr), 64'(nxt_addr));
            n_hs++;
            last_hs_addr = int'(mem_addr);
            lat_addr     = int'(mem_addr);
            outstanding  = 1;
            lat_cnt      = int'($urandom_range(32'(lat_hi), 32'(lat_lo)));
        end
        request     = req_in;
        frame_start = fs_in;

        pv_e = req_in;
        if (req_in) begin
            if (q.size() == 0) begin
                rgb_e = '0;
                uf_m  = 1;
            end else begin
                rgb_e = q.pop_front();
            end
        end
        if (v) begin
            outstanding = 0;
            if (flush_m || fs_in) begin
                restart_m();
            end else begin
                q.push_back(unpack(d1, d2));
                nxt_addr++;
                if (nxt_addr == NPIX) done_m = 1;
            end
        end else if (fs_in && !flush_m) begin
            if (outstanding) flush_m = 1;
            else restart_m();
        end

        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 64'(mem_req), 64'(0));
        check({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_rgb"}, 64'({vga_r, vga_g, vga_b}), 64'(0));
        check({tag, "_pv"}, 64'(pix_valid), 64'(0));
        check({tag, "_uf"}, 64'(underflow), 64'(0));
        check({tag, "_done"}, 64'(fetch_done), 64'(0));
    endtask

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) begin
            mem1[i] = 16'($urandom);
            mem2[i] = 16'($urandom);
        end
    endtask

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0155, 10'h155, 10'h3E0, 10'h3FF};
        vecs[1] = '{16'h0000, 16'h0000, 10'h000, 10'h000, 10'h000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[3] = '{16'h8000, 16'h8000, 10'h000, 10'h000, 10'h000};
        vecs[4] = '{16'h0400, 16'h0000, 10'h000, 10'h020, 10'h000};
        vecs[5] = '{16'h0000, 16'h0400, 10'h000, 10'h001, 10'h000};
        vecs[6] = '{16'h1234, 16'h5678, 10'h278, 10'h095, 10'h234};

        fill_mem();
        clear_inputs();
        d1 = '0;
        d2 = '0;
        reset_model();
        rst_n = 1;
        #2 rst_n = 0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // no fetch without a frame start
        repeat (5) step(0, 0);

        // unpack vectors through the whole fetch path
        ack_pct = 100; lat_lo = 1; lat_hi = 1;
        foreach (vecs[i]) begin
            mem1[0] = vecs[i].w1;
            mem2[0] = vecs[i].w2;
            step(0, 1);
            for (int k = 0; k < 20 && (flush_m || q.size() == 0); k++) step(0, 0);
            step(1, 0);
            check("vec_pv", 64'(pix_valid), 64'(1));
            check("vec_r", 64'(vga_r), 64'(vecs[i].r));
            check("vec_g", 64'(vga_g), 64'(vecs[i].g));
            check("vec_b", 64'(vga_b), 64'(vecs[i].b));
        end
        fill_mem();

        // backpressure: exactly DEPTH fetches, then one more per pop
        step(0, 1);
        for (int k = 0; k < 10 && flush_m; k++) step(0, 0);
        n_hs = 0;
        repeat (30) step(0, 0);
        check("bp_count", 64'(n_hs), 64'(DEPTH));
        check("bp_req_low", 64'(mem_req), 64'(0));
        n_hs = 0;
        step(1, 0);
        repeat (20) step(0, 0);
        check("bp_one_more", 64'(n_hs), 64'(1));
        check("bp_addr", 64'(last_hs_addr), 64'(DEPTH));

        // underflow is sticky until the next frame start
        ack_pct = 0;
        step(0, 1);
        for (int k = 0; k < 10 && flush_m; k++) step(0, 0);
        step(1, 0);
        check("uf_set", 64'(underflow), 64'(1));
        check("uf_rgb", 64'({vga_r, vga_g, vga_b}), 64'(0));
        check("uf_pv", 64'(pix_valid), 64'(1));
        ack_pct = 100;
        repeat (12) step(0, 0);
        check("uf_sticky", 64'(underflow), 64'(1));
        step(0, 1);
        for (int k = 0; k < 10 && flush_m; k++) step(0, 0);
        check("uf_cleared", 64'(underflow), 64'(0));

        // restart while waiting for address 7
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 300 && !(outstanding && lat_addr == 7 && lat_cnt >= 2); k++) step(1, 0);
        check("rs_reached7", 64'(outstanding && lat_addr == 7), 64'(1));
        step(0, 1);
        check("rs_flush_req", 64'(mem_req), 64'(0));
        for (int k = 0; k < 10 && flush_m; k++) step(0, 0);
        check("rs_flush_end", 64'(flush_m), 64'(0));
        check("rs_uf_clear", 64'(underflow), 64'(0));
        ack_pct = 0;
        for (int k = 0; k < 10 && !mem_req; k++) step(0, 0);
        check("rs_req", 64'(mem_req), 64'(1));
        check("rs_addr0", 64'(mem_addr), 64'(0));
        step(1, 0);
        check("rs_fifo_empty", 64'(underflow), 64'(1));

        // end of frame under continuous display requests
        ack_pct = 100; lat_lo = 1; lat_hi = 3;
        step(0, 1);
        for (int k = 0; k < 10 && flush_m; k++) step(0, 0);
        n_hs = 0;
        for (int k = 0; k < 300 && !fetch_done; k++) step(1, 0);
        repeat (10) step(1, 0);
        check("eof_count", 64'(n_hs), 64'(NPIX));
        check("eof_done", 64'(fetch_done), 64'(1));
        check("eof_req", 64'(mem_req), 64'(0));

        // randomized frames with random restarts
        for (int f = 0; f < 8; f++) begin
            fill_mem();
            ack_pct = int'($urandom_range(100, 30));
            lat_lo  = 1;
            lat_hi  = int'($urandom_range(4, 1));
            step(0, 1);
            for (int k = 0; k < 300; k++)
                step($urandom_range(99) < 40, $urandom_range(999) < 5);
        end

        // reset in the middle of a fetch
        ack_pct = 100; lat_lo = 4; lat_hi = 4;
        step(0, 1);
        for (int k = 0; k < 20 && !(outstanding && lat_cnt >= 2); k++) step(1, 0);
        check("mid_in_wait", 64'(outstanding), 64'(1));
        rst_n = 0;
        #1 check_all_zero("mid_reset");
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        repeat (8) step(0, 0);
        check("mid_req_low", 64'(mem_req), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
